// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes and run-state FSM encoding.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'd0;
    localparam logic [3:0] INOP    = 4'd1;
    localparam logic [3:0] IRRMOVQ = 4'd2;
    localparam logic [3:0] IIRMOVQ = 4'd3;
    localparam logic [3:0] IRMMOVQ = 4'd4;
    localparam logic [3:0] IMRMOVQ = 4'd5;
    localparam logic [3:0] IOPQ    = 4'd6;
    localparam logic [3:0] IJXX    = 4'd7;
    localparam logic [3:0] ICALL   = 4'd8;
    localparam logic [3:0] IRET    = 4'd9;
    localparam logic [3:0] IPUSHQ  = 4'd10;
    localparam logic [3:0] IPOPQ   = 4'd11;

    localparam logic [3:0] RNONE   = 4'hF;

    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [2:0] SHLT    = 3'd2;
    localparam logic [2:0] SADR    = 3'd3;
    localparam logic [2:0] SINS    = 3'd4;

    typedef enum logic [1:0] {
        CPU_FLUSH  = 2'd0,
        CPU_RUN    = 2'd1,
        CPU_FREEZE = 2'd2,
        CPU_STOP   = 2'd3
    } cpu_state_e;

    // A status that must stop the core once it reaches write-back.
    function automatic logic is_exc(input logic [2:0] s);
        return (s == SADR) || (s == SINS) || (s == SHLT);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts on inc, sticks at all-ones, never wraps.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard detection, stall/bubble generation,
// run-state sequencing (flush/run/freeze/stop) and performance counters.
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int FLUSH_CYCLES = 5,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [3:0]       W_icode,
    input  logic [2:0]       W_stat,
    input  logic             dbg_freeze,
    output logic             F_stall,
    output logic             D_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_bubble,
    output logic             set_cc,
    output logic [1:0]       cpu_state,
    output logic [2:0]       final_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    cpu_state_e     state;
    cpu_state_e     state_nx;
    logic [FW-1:0]  flush_cnt;
    logic [2:0]     final_q;

    logic lu;
    logic ret_h;
    logic mp;
    logic m_exc;
    logic w_exc;

    assign lu    = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign ret_h = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
    assign mp    = (E_icode == IJXX) && !e_Cnd;
    assign m_exc = is_exc(m_stat);
    assign w_exc = is_exc(W_stat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CPU_FLUSH;
            flush_cnt <= '0;
            final_q   <= SAOK;
        end else begin
            state <= state_nx;
            if (state == CPU_FLUSH) begin
                flush_cnt <= flush_cnt + FW'(1);
            end
            if ((state == CPU_RUN) && w_exc) begin
                final_q <= W_stat;
            end
        end
    end

    always_comb begin
        state_nx = state;
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        W_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_bubble = 1'b0;
        set_cc   = 1'b0;
        unique case (state)
            CPU_FLUSH: begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_bubble = 1'b1;
                if (flush_cnt == FLUSH_LAST) begin
                    state_nx = CPU_RUN;
                end
            end
            CPU_RUN: begin
                F_stall  = lu | ret_h;
                D_stall  = lu;
                D_bubble = mp | (!lu & ret_h);
                E_bubble = mp | lu;
                M_bubble = m_exc | w_exc;
                W_stall  = w_exc;
                set_cc   = (E_icode == IOPQ) && !m_exc && !w_exc;
                // A faulting write-back takes priority over a debug freeze request.
                if (w_exc) begin
                    state_nx = CPU_STOP;
                end else if (dbg_freeze) begin
                    state_nx = CPU_FREEZE;
                end
            end
            CPU_FREEZE: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                W_stall  = 1'b1;
                M_bubble = 1'b1;
                if (!dbg_freeze) begin
                    state_nx = CPU_RUN;
                end
            end
            CPU_STOP: begin
                F_stall  = 1'b1;
                W_stall  = 1'b1;
                M_bubble = 1'b1;
            end
            default: begin
                state_nx = CPU_FLUSH;
            end
        endcase
    end

    assign cpu_state  = state;
    assign final_stat = final_q;

    logic counting;
    logic in_run;

    assign counting = (state == CPU_RUN) || (state == CPU_FREEZE);
    assign in_run   = (state == CPU_RUN);

    sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (counting),
        .count (cyc_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (in_run && (W_stat == SAOK) && (W_icode != INOP)),
        .count (ret_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (in_run && lu),
        .count (lu_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mp_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (in_run && mp),
        .count (mp_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard scenarios plus randomized traffic
// checked against a behavioural model of the control rules.
module tb_pipe_ctrl;

    localparam int FLUSH = 5;
    localparam int CW    = 8;
    localparam int MAXV  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [3:0]    D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
    logic          e_Cnd, dbg_freeze;
    logic [2:0]    m_stat, W_stat;
    logic          F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, W_bubble, set_cc;
    logic [1:0]    cpu_state;
    logic [2:0]    final_stat;
    logic [CW-1:0] cyc_cnt, ret_cnt, lu_cnt, mp_cnt;
    logic [7:0]    ctl;

    pipe_ctrl #(.FLUSH_CYCLES(FLUSH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
        .dbg_freeze(dbg_freeze),
        .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_bubble(W_bubble),
        .set_cc(set_cc), .cpu_state(cpu_state), .final_stat(final_stat),
        .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt)
    );

    assign ctl = {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, W_bubble, set_cc};

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: 0 flush, 1 run, 2 freeze, 3 stop
    int          m_state;
    int          m_flush;
    int unsigned m_cyc, m_ret, m_lu, m_mp;
    logic [2:0]  m_final;

    function automatic bit f_exc(input logic [2:0] s);
        return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    endfunction

    function automatic bit f_lu();
        return ((E_icode == 4'd5) || (E_icode == 4'd11)) && (E_dstM != 4'd15) &&
               ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    endfunction

    function automatic bit f_ret();
        return (D_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
    endfunction

    function automatic bit f_mp();
        return (E_icode == 4'd7) && !e_Cnd;
    endfunction

    function automatic int unsigned sat(input int unsigned v);
        return (v >= MAXV) ? MAXV : v + 1;
    endfunction

    // Expected {F_stall,D_stall,W_stall,D_bubble,E_bubble,M_bubble,W_bubble,set_cc}
    function automatic logic [7:0] exp_ctl();
        bit fs = 0, ds = 0, ws = 0, db = 0, eb = 0, mb = 0, wb = 0, cc = 0;
        bit lu = f_lu(), rt = f_ret(), mp = f_mp();
        case (m_state)
            0: begin fs = 1; db = 1; eb = 1; mb = 1; wb = 1; end
            1: begin
                fs = lu | rt; ds = lu; db = mp | (!lu && rt); eb = mp | lu;
                mb = f_exc(m_stat) | f_exc(W_stat); ws = f_exc(W_stat);
                cc = (E_icode == 4'd6) && !f_exc(m_stat) && !f_exc(W_stat);
            end
            2: begin fs = 1; ds = 1; ws = 1; mb = 1; end
            default: begin fs = 1; ws = 1; mb = 1; end
        endcase
        return {fs, ds, ws, db, eb, mb, wb, cc};
    endfunction

    task automatic model_reset();
        m_state = 0; m_flush = 0;
        m_cyc = 0; m_ret = 0; m_lu = 0; m_mp = 0;
        m_final = 3'd1;
    endtask

    // One clock: update the model from the current inputs, cross the edge, return at negedge.
    task automatic advance();
        int ns = m_state;
        if (m_state == 0) begin
            m_flush++;
            if (m_flush == FLUSH) ns = 1;
        end else if (m_state == 1) begin
            m_cyc = sat(m_cyc);
            if (W_stat == 3'd1 && W_icode != 4'd1) m_ret = sat(m_ret);
            if (f_lu()) m_lu = sat(m_lu);
            if (f_mp()) m_mp = sat(m_mp);
            if (f_exc(W_stat)) begin ns = 3; m_final = W_stat; end
            else if (dbg_freeze) ns = 2;
        end else if (m_state == 2) begin
            m_cyc = sat(m_cyc);
            if (!dbg_freeze) ns = 1;
        end
        @(posedge clk);
        m_state = ns;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        D_icode = 4'd1; E_icode = 4'd1; M_icode = 4'd1; W_icode = 4'd1;
        d_srcA = 4'd15; d_srcB = 4'd15; E_dstM = 4'd15; e_Cnd = 1'b0;
        m_stat = 3'd1; W_stat = 3'd1; dbg_freeze = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({cpu_state, final_stat, ctl} !== {2'd0, 3'd1, 8'h9E}) begin
            failures++;
            $display("FAIL reset_state: got st=%0d fs=%0d ctl=%h expected st=0 fs=1 ctl=9e", cpu_state, final_stat, ctl);
        end
        checks++;
        if ({cyc_cnt, ret_cnt, lu_cnt, mp_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_counters: got %0d %0d %0d %0d expected all 0", cyc_cnt, ret_cnt, lu_cnt, mp_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < FLUSH; i++) begin
            #1;
            checks++;
            if (cpu_state !== 2'd0 || ctl !== 8'h9E) begin
                failures++;
                $display("FAIL flush_cycle%0d: got st=%0d ctl=%h expected st=0 ctl=9e", i, cpu_state, ctl);
            end
            advance();
        end
        #1;
        checks++;
        if (cpu_state !== 2'd1 || cyc_cnt !== 8'd0 || ctl !== 8'h00) begin
            failures++;
            $display("FAIL flush_release: got st=%0d cyc=%0d ctl=%h expected st=1 cyc=0 ctl=00", cpu_state, cyc_cnt, ctl);
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        E_icode = 4'd5; E_dstM = 4'd3; d_srcB = 4'd3;
        #1;
        checks++;
        if (ctl !== 8'hC8 || ctl !== exp_ctl()) begin
            failures++;
            $display("FAIL load_use_srcB: got ctl=%h expected c8", ctl);
        end
        advance();
        #1;
        checks++;
        if (lu_cnt !== CW'(m_lu) || m_lu != 1) begin
            failures++;
            $display("FAIL load_use_count: got %0d expected %0d", lu_cnt, m_lu);
        end
        E_icode = 4'd11; E_dstM = 4'd4; d_srcA = 4'd4; d_srcB = 4'd15;
        #1;
        checks++;
        if (ctl !== 8'hC8) begin
            failures++;
            $display("FAIL load_use_popq_srcA: got ctl=%h expected c8", ctl);
        end
        advance();
        E_dstM = 4'd15; d_srcA = 4'd15;
        #1;
        checks++;
        if (ctl !== 8'h00 || lu_cnt !== CW'(m_lu)) begin
            failures++;
            $display("FAIL load_use_rnone: got ctl=%h lu=%0d expected ctl=00 lu=%0d", ctl, lu_cnt, m_lu);
        end
        advance();
    endtask

    task automatic test_mispredict();
        idle_inputs();
        E_icode = 4'd7; e_Cnd = 1'b0;
        #1;
        checks++;
        if (ctl !== 8'h18) begin
            failures++;
            $display("FAIL mispredict_ctl: got ctl=%h expected 18", ctl);
        end
        advance();
        e_Cnd = 1'b1;
        #1;
        checks++;
        if (ctl !== 8'h00 || mp_cnt !== CW'(m_mp) || m_mp != 1) begin
            failures++;
            $display("FAIL jump_taken: got ctl=%h mp=%0d expected ctl=00 mp=%0d", ctl, mp_cnt, m_mp);
        end
        advance();
        #1;
        checks++;
        if (mp_cnt !== CW'(m_mp)) begin
            failures++;
            $display("FAIL mp_count_hold: got %0d expected %0d", mp_cnt, m_mp);
        end
    endtask

    task automatic test_ret();
        idle_inputs();
        for (int s = 0; s < 4; s++) begin
            D_icode = (s == 0) ? 4'd9 : 4'd1;
            E_icode = (s == 1) ? 4'd9 : 4'd1;
            M_icode = (s == 2) ? 4'd9 : 4'd1;
            #1;
            checks++;
            if (ctl !== ((s < 3) ? 8'h90 : 8'h00)) begin
                failures++;
                $display("FAIL ret_stage%0d: got ctl=%h expected %h", s, ctl, (s < 3) ? 8'h90 : 8'h00);
            end
            advance();
        end
    endtask

    task automatic test_freeze();
        idle_inputs();
        dbg_freeze = 1'b1;
        advance();
        E_icode = 4'd5; E_dstM = 4'd2; d_srcA = 4'd2;
        #1;
        checks++;
        if (cpu_state !== 2'd2 || ctl !== 8'hE4) begin
            failures++;
            $display("FAIL freeze_enter: got st=%0d ctl=%h expected st=2 ctl=e4", cpu_state, ctl);
        end
        advance();
        advance();
        #1;
        checks++;
        if (lu_cnt !== CW'(m_lu) || cyc_cnt !== CW'(m_cyc)) begin
            failures++;
            $display("FAIL freeze_counts: got lu=%0d cyc=%0d expected lu=%0d cyc=%0d", lu_cnt, cyc_cnt, m_lu, m_cyc);
        end
        idle_inputs();
        advance();
        #1;
        checks++;
        if (cpu_state !== 2'd1) begin
            failures++;
            $display("FAIL freeze_exit: got st=%0d expected 1", cpu_state);
        end
    endtask

    task automatic test_exception();
        idle_inputs();
        W_stat = 3'd3; dbg_freeze = 1'b1;
        #1;
        checks++;
        if (ctl !== 8'h24) begin
            failures++;
            $display("FAIL exc_run_ctl: got ctl=%h expected 24", ctl);
        end
        advance();
        W_stat = 3'd1; W_icode = 4'd6; E_icode = 4'd7; dbg_freeze = 1'b0;
        #1;
        checks++;
        if (cpu_state !== 2'd3 || final_stat !== 3'd3 || ctl !== 8'hA4) begin
            failures++;
            $display("FAIL exc_stop: got st=%0d fs=%0d ctl=%h expected st=3 fs=3 ctl=a4", cpu_state, final_stat, ctl);
        end
        repeat (4) advance();
        #1;
        checks++;
        if (cpu_state !== 2'd3 || {cyc_cnt, ret_cnt, lu_cnt, mp_cnt} !== {CW'(m_cyc), CW'(m_ret), CW'(m_lu), CW'(m_mp)}) begin
            failures++;
            $display("FAIL stop_frozen: got st=%0d cnt=%0d/%0d/%0d/%0d expected st=3 cnt=%0d/%0d/%0d/%0d",
                     cpu_state, cyc_cnt, ret_cnt, lu_cnt, mp_cnt, m_cyc, m_ret, m_lu, m_mp);
        end
    endtask

    task automatic test_saturation();
        idle_inputs();
        do_reset();
        repeat (FLUSH) advance();
        W_icode = 4'd6;
        repeat (MAXV + 3) advance();
        #1;
        checks++;
        if (ret_cnt !== CW'(MAXV) || cyc_cnt !== CW'(MAXV) || m_ret != MAXV) begin
            failures++;
            $display("FAIL ret_saturate: got ret=%0d cyc=%0d expected %0d", ret_cnt, cyc_cnt, MAXV);
        end
        advance();
        #1;
        checks++;
        if (ret_cnt !== CW'(MAXV)) begin
            failures++;
            $display("FAIL ret_no_wrap: got %0d expected %0d", ret_cnt, MAXV);
        end
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (cpu_state !== 2'd0 || {cyc_cnt, ret_cnt, lu_cnt, mp_cnt} !== '0) begin
            failures++;
            $display("FAIL midrun_reset: got st=%0d ret=%0d cyc=%0d expected st=0 counters 0", cpu_state, ret_cnt, cyc_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [3:0] pick [6] = '{4'd5, 4'd11, 4'd7, 4'd9, 4'd6, 4'd1};
        logic [3:0] tmp;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tmp = pick[$urandom_range(0, 5)];
            E_icode = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 11)) : tmp;
            D_icode = ($urandom_range(0, 5) == 0) ? 4'd9 : 4'($urandom_range(0, 11));
            M_icode = ($urandom_range(0, 5) == 0) ? 4'd9 : 4'($urandom_range(0, 11));
            W_icode = 4'($urandom_range(0, 11));
            d_srcA = 4'($urandom_range(0, 15));
            d_srcB = 4'($urandom_range(0, 15));
            E_dstM = ($urandom_range(0, 2) == 0) ? d_srcA : 4'($urandom_range(0, 15));
            e_Cnd = 1'($urandom_range(0, 1));
            m_stat = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            W_stat = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            dbg_freeze = ($urandom_range(0, 7) == 0);
            #1;
            checks++;
            if ({ctl, cpu_state, final_stat, cyc_cnt, ret_cnt, lu_cnt, mp_cnt} !==
                {exp_ctl(), 2'(m_state), m_final, CW'(m_cyc), CW'(m_ret), CW'(m_lu), CW'(m_mp)}) begin
                failures++;
                $display("FAIL random_cycle%0d: got ctl=%h st=%0d fs=%0d cnt=%0d/%0d/%0d/%0d expected ctl=%h st=%0d fs=%0d cnt=%0d/%0d/%0d/%0d",
                         c, ctl, cpu_state, final_stat, cyc_cnt, ret_cnt, lu_cnt, mp_cnt,
                         exp_ctl(), m_state, m_final, m_cyc, m_ret, m_lu, m_mp);
            end
            if ((m_state == 3 && $urandom_range(0, 3) == 0) || $urandom_range(0, 149) == 0)
                do_reset();
            else
                advance();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mispredict();
        test_ret();
        test_freeze();
        test_exception();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
